// File: rtl/dsp_pkg.sv
// Shared DSP definitions: I2S frame geometry and the stereo sample type from the mixer.
package dsp_pkg;

  localparam int unsigned I2S_SLOTS = 32;
  localparam int unsigned I2S_WORD  = 16;

  typedef struct packed {
    logic [I2S_WORD-1:0] l;
    logic [I2S_WORD-1:0] r;
  } stereo_sample_t;

endpackage

// File: rtl/i2s_clkgen.sv
// Free-running I2S bit clock divider and BCLK slot counter.
// 'fall' marks the clk in which bclk goes 1->0; slot_ctr advances on that clk.
module i2s_clkgen
  import dsp_pkg::*;
#(
  parameter int unsigned BCLK_HALF = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         bclk,
  output logic                         fall,
  output logic [$clog2(I2S_SLOTS)-1:0] slot_ctr
);

  localparam int unsigned DivW  = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int unsigned SlotW = $clog2(I2S_SLOTS);

  logic [DivW-1:0]  div_q, div_d;
  logic             bclk_q, bclk_d;
  logic [SlotW-1:0] slot_q, slot_d;
  logic             terminal;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
      slot_q <= '0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
      slot_q <= slot_d;
    end
  end

  always_comb begin
    terminal = (div_q == DivW'(BCLK_HALF - 1));
    fall     = terminal & bclk_q;
    div_d    = terminal ? '0 : div_q + 1'b1;
    bclk_d   = terminal ? ~bclk_q : bclk_q;
    // 5-bit counter wraps 31->0 naturally
    slot_d   = fall ? slot_q + 1'b1 : slot_q;
  end

  always_comb begin
    bclk     = bclk_q;
    slot_ctr = slot_q;
  end

endmodule

// File: rtl/dsp_i2s_tx.sv
// I2S transmitter: stages DSP stereo samples and serialises them MSB-first with
// the I2S one-bit delay. Capture is cpu_en gated; the serial clocks never stall.
module dsp_i2s_tx
  import dsp_pkg::*;
#(
  parameter int unsigned BCLK_HALF = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_en,
  input  logic                exe_32khz,
  input  logic [I2S_WORD-1:0] sample_l,
  input  logic [I2S_WORD-1:0] sample_r,
  input  logic                mute,
  output logic                i2s_bclk,
  output logic                i2s_lrck,
  output logic                i2s_sdata,
  output logic                underrun
);

  localparam int unsigned SlotW = $clog2(I2S_SLOTS);

  logic             fall;
  logic [SlotW-1:0] slot_ctr;

  i2s_clkgen #(
    .BCLK_HALF(BCLK_HALF)
  ) u_clkgen (
    .clk     (clk),
    .reset   (reset),
    .bclk    (i2s_bclk),
    .fall    (fall),
    .slot_ctr(slot_ctr)
  );

  stereo_sample_t       staging_q, staging_d;
  logic                 fresh_q, fresh_d;
  logic [I2S_SLOTS-1:0] frame_q, frame_d;
  logic                 prev_lsb_q, prev_lsb_d;
  logic                 underrun_q, underrun_d;
  logic                 capture, load;
  logic [SlotW-1:0]     bit_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      staging_q  <= '0;
      fresh_q    <= 1'b0;
      frame_q    <= '0;
      prev_lsb_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      staging_q  <= staging_d;
      fresh_q    <= fresh_d;
      frame_q    <= frame_d;
      prev_lsb_q <= prev_lsb_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    capture    = cpu_en & exe_32khz;
    load       = fall & (slot_ctr == SlotW'(I2S_SLOTS - 1));
    staging_d  = staging_q;
    fresh_d    = fresh_q;
    frame_d    = frame_q;
    prev_lsb_d = prev_lsb_q;
    if (load) begin
      prev_lsb_d = frame_q[0];
      frame_d    = mute ? '0 : staging_q;
      fresh_d    = 1'b0;
    end
    // A capture in the load clk wins: the old word is framed, the new one stays fresh
    if (capture) begin
      staging_d = '{l: sample_l, r: sample_r};
      fresh_d   = 1'b1;
    end
    underrun_d = load & ~fresh_q & ~capture;
  end

  // All sources change only on fall events, so outputs are stable across BCLK rise
  always_comb begin
    bit_idx   = '0 - slot_ctr;
    i2s_lrck  = (slot_ctr >= SlotW'(I2S_SLOTS / 2));
    i2s_sdata = (slot_ctr == '0) ? prev_lsb_q : frame_q[bit_idx];
    underrun  = underrun_q;
  end

endmodule

// File: tb/tb_dsp_i2s_tx.sv
// Self-checking bench for dsp_i2s_tx: time-based reference model, vector table and corner cases.
module tb_dsp_i2s_tx;

  localparam int unsigned BH    = 2;
  localparam int          FRAME = 64 * BH;

  logic        clk = 1'b0;
  logic        reset, cpu_en, exe_32khz, mute;
  logic [15:0] sample_l, sample_r;
  logic        i2s_bclk, i2s_lrck, i2s_sdata, underrun;

  always #5 clk = ~clk;

  dsp_i2s_tx #(
    .BCLK_HALF(BH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_en   (cpu_en),
    .exe_32khz(exe_32khz),
    .sample_l (sample_l),
    .sample_r (sample_r),
    .mute     (mute),
    .i2s_bclk (i2s_bclk),
    .i2s_lrck (i2s_lrck),
    .i2s_sdata(i2s_sdata),
    .underrun (underrun)
  );

  int          checks, failures;
  int          n;          // clk edges since reset released
  logic [31:0] m_stage, m_frame;
  logic        m_fresh, m_prev, m_under;
  logic [31:0] acc, got_word;
  int          under_cnt;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        mute;
    logic [31:0] exp_word;
    int          exp_under;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int mslot();
    return (n / (2 * BH)) % 32;
  endfunction

  // One clk: update the model from the spec rules, then compare all outputs.
  task automatic step();
    int   slot;
    logic cap, load, exp_sd;
    @(posedge clk);
    if (reset) begin
      n = 0; m_stage = '0; m_fresh = 1'b0; m_frame = '0; m_prev = 1'b0; m_under = 1'b0;
    end else begin
      n++;
      cap     = cpu_en && exe_32khz;
      load    = (n % FRAME) == 0;
      m_under = load && !m_fresh && !cap;
      if (load) begin
        m_prev  = m_frame[0];
        m_frame = mute ? 32'h0 : m_stage;
        m_fresh = 1'b0;
      end
      if (cap) begin
        m_stage = {sample_l, sample_r};
        m_fresh = 1'b1;
      end
    end
    #1;
    slot   = mslot();
    exp_sd = (slot == 0) ? m_prev : m_frame[5'(32 - slot)];
    check("bclk", 32'(i2s_bclk), 32'((n / BH) % 2));
    check("lrck", 32'(i2s_lrck), 32'(slot >= 16));
    check("sdata", 32'(i2s_sdata), 32'(exp_sd));
    check("underrun", 32'(underrun), 32'(m_under));
    if (underrun) under_cnt++;
    if (!reset && n > 0 && (n % (2 * BH)) == 0) begin
      if (slot == 0) begin
        acc[0]   = i2s_sdata;
        got_word = acc;
      end else begin
        acc[5'(32 - slot)] = i2s_sdata;
      end
    end
  endtask

  task automatic run_to_load();
    for (int k = 0; k < FRAME; k++) begin
      step();
      if (n % FRAME == 0) break;
    end
  endtask

  task automatic run_to_slot(input int s);
    for (int k = 0; k < FRAME && mslot() != s; k++) step();
  endtask

  task automatic capture_one(input logic [15:0] l, input logic [15:0] r);
    sample_l  = l;
    sample_r  = r;
    exe_32khz = 1'b1;
    step();
    exe_32khz = 1'b0;
  endtask

  initial begin
    int   k;
    logic prev_b;
    checks = 0; failures = 0; n = 0; under_cnt = 0;
    m_stage = '0; m_frame = '0; m_fresh = 1'b0; m_prev = 1'b0; m_under = 1'b0;
    acc = '0; got_word = '0;
    reset = 1'b1; cpu_en = 1'b1; exe_32khz = 1'b0; mute = 1'b0;
    sample_l = '0; sample_r = '0;

    vecs[0] = '{l: 16'h8001, r: 16'h7FFE, mute: 1'b0, exp_word: 32'h8001_7FFE, exp_under: 1};
    vecs[1] = '{l: 16'h0000, r: 16'hFFFF, mute: 1'b0, exp_word: 32'h0000_FFFF, exp_under: 1};
    vecs[2] = '{l: 16'hA5A5, r: 16'h5A5A, mute: 1'b0, exp_word: 32'hA5A5_5A5A, exp_under: 1};
    vecs[3] = '{l: 16'hFFFF, r: 16'hFFFF, mute: 1'b1, exp_word: 32'h0000_0000, exp_under: 1};

    step(); step();
    check("reset_outs", {28'h0, i2s_bclk, i2s_lrck, i2s_sdata, underrun}, 32'h0);
    reset = 1'b0;

    // BCLK period between two rising edges
    prev_b = i2s_bclk;
    for (k = 0; k < 4 * BH && !(i2s_bclk && !prev_b); k++) begin prev_b = i2s_bclk; step(); end
    prev_b = i2s_bclk;
    k = 0;
    do begin prev_b = i2s_bclk; step(); k++; end while (!(i2s_bclk && !prev_b) && k < 8 * BH);
    check("bclk_period", k, 2 * BH);

    // Vector table: capture mid-frame (mute at slot 8), frame it, read it back serially
    foreach (vecs[i]) begin
      run_to_slot(8);
      under_cnt = 0;
      mute = vecs[i].mute;
      capture_one(vecs[i].l, vecs[i].r);
      run_to_load();
      mute = 1'b0;
      run_to_load();
      check($sformatf("vec%0d_word", i), got_word, vecs[i].exp_word);
      check($sformatf("vec%0d_underrun", i), under_cnt, vecs[i].exp_under);
    end

    // Underrun: one capture then three stale frames
    run_to_slot(8);
    capture_one(16'hCAFE, 16'hBEEF);
    run_to_load();
    under_cnt = 0;
    for (int f = 0; f < 3; f++) begin
      run_to_load();
      check($sformatf("stale%0d_word", f), got_word, 32'hCAFE_BEEF);
    end
    check("stale_underruns", under_cnt, 3);

    // Collision: capture in the exact clk of the 31->0 fall event
    for (k = 0; k < FRAME && ((n + 1) % FRAME) != 0; k++) step();
    under_cnt = 0;
    capture_one(16'h1234, 16'h5678);
    run_to_load();
    check("collide_old_word", got_word, 32'hCAFE_BEEF);
    check("collide_no_underrun", under_cnt, 0);
    run_to_load();
    check("collide_new_word", got_word, 32'h1234_5678);

    // Reset at slot 20; first load after 32 BCLKs flags underrun
    run_to_slot(20);
    reset = 1'b1;
    step();
    check("midreset_outs", {28'h0, i2s_bclk, i2s_lrck, i2s_sdata, underrun}, 32'h0);
    reset = 1'b0;
    for (k = 0; k < 2 * FRAME && !underrun; k++) step();
    check("first_load_clks", k, FRAME);

    // cpu_en gating: staging holds while exe_32khz toggles
    run_to_slot(8);
    capture_one(16'h0F0F, 16'hF0F0);
    run_to_load();
    cpu_en = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (k = 0; k < FRAME; k++) begin
        exe_32khz = ($urandom_range(0, 3) == 0);
        sample_l  = 16'($urandom);
        sample_r  = 16'($urandom);
        step();
        if (n % FRAME == 0) break;
      end
      check($sformatf("gated%0d_word", f), got_word, 32'h0F0F_F0F0);
    end
    exe_32khz = 1'b0;
    cpu_en    = 1'b1;

    // Randomised traffic against the model
    for (int c = 0; c < 12 * FRAME; c++) begin
      exe_32khz = ($urandom_range(0, 99) == 0);
      cpu_en    = ($urandom_range(0, 7) != 0);
      sample_l  = 16'($urandom);
      sample_r  = 16'($urandom);
      if ($urandom_range(0, 299) == 0) mute = ~mute;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
